// File: rtl/tag_lookup_pipe_if.sv
// tag_lookup_pipe_if
//   Bundles every non-clock/reset signal of tag_lookup_pipe.
//   slave  : the lookup pipeline (receives requests, flush and victim vector).
//   master : the requester / replacement-policy side.
//   Signals:
//     i_req_vld / o_req_rdy         request handshake
//     i_req_setIdx / i_req_tag      request set index and tag
//     i_flush                       invalidate-all pulse
//     o_setIdx                      set index presented to the replacement block (s0)
//     i_replace_vec                 one-hot victim for the s0 set, sampled in s1
//     o_update_req / o_wayhit_vec   replacement update strobe and accessed way (s1)
//     o_resp_vld / o_resp_hit /
//     o_resp_way                    lookup result (s1)
interface tag_lookup_pipe_if #(
  parameter int SETS  = 32,
  parameter int WAYS  = 4,
  parameter int TAG_W = 20
);
  localparam int SET_W = $clog2(SETS);

  logic             i_req_vld;
  logic             o_req_rdy;
  logic [SET_W-1:0] i_req_setIdx;
  logic [TAG_W-1:0] i_req_tag;
  logic             i_flush;
  logic [SET_W-1:0] o_setIdx;
  logic [WAYS-1:0]  i_replace_vec;
  logic             o_update_req;
  logic [WAYS-1:0]  o_wayhit_vec;
  logic             o_resp_vld;
  logic             o_resp_hit;
  logic [WAYS-1:0]  o_resp_way;

  modport slave (
    input  i_req_vld, i_req_setIdx, i_req_tag, i_flush, i_replace_vec,
    output o_req_rdy, o_setIdx, o_update_req, o_wayhit_vec,
           o_resp_vld, o_resp_hit, o_resp_way
  );

  modport master (
    output i_req_vld, i_req_setIdx, i_req_tag, i_flush, i_replace_vec,
    input  o_req_rdy, o_setIdx, o_update_req, o_wayhit_vec,
           o_resp_vld, o_resp_hit, o_resp_way
  );
endinterface

// File: rtl/tag_lookup_pipe.sv
// tag_lookup_pipe
//   Two-stage set-associative tag lookup.
//   s0: request accepted, set index shown to the replacement block.
//   s1: tag compare against the set; on a miss the chosen way (first invalid,
//       else the replacement victim) is written with the new tag.
//   A RUN/FLUSH state machine clears one set's valid bits per cycle on i_flush.
//   Ports:
//     clk  : clock, all state on the rising edge
//     rst  : synchronous active-high reset
//     bus  : tag_lookup_pipe_if.slave (request, flush, replacement, response)
module tag_lookup_pipe #(
  parameter int SETS  = 32,
  parameter int WAYS  = 4,
  parameter int TAG_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  tag_lookup_pipe_if.slave  bus
);
  localparam int SET_W = $clog2(SETS);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_flush_active;
  logic [SET_W-1:0] r_flush_cnt;

  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [WAYS-1:0]  r_valid [SETS];

  logic             r_s1_vld;
  logic [SET_W-1:0] r_s1_set;
  logic [TAG_W-1:0] r_s1_tag;

  logic             w_hazard;
  logic             w_rdy;
  logic             w_accept;
  logic             w_hit;
  logic             w_miss_wr;
  logic [WAYS-1:0]  w_match;
  logic [WAYS-1:0]  w_invalid;
  logic [WAYS-1:0]  w_match_low;
  logic [WAYS-1:0]  w_invalid_low;
  logic [WAYS-1:0]  w_way;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    w_flush_active = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.i_flush) w_state_next = FLUSH;
      end
      FLUSH: begin
        // i_flush is deliberately not looked at here: a repeat pulse must not
        // restart the sweep.
        w_flush_active = 1'b1;
        if (r_flush_cnt == SET_W'(SETS - 1)) w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  // Counter wraps back to 0 on the last set because SETS is a power of 2.
  always_ff @(posedge clk) begin
    if (rst)                   r_flush_cnt <= '0;
    else if (r_state == FLUSH) r_flush_cnt <= r_flush_cnt + SET_W'(1);
    else                       r_flush_cnt <= '0;
  end

  // ---------------- s0 ----------------
  // Stall a request to the set currently in s1 so its replacement update
  // and any tag write land before the set is looked up again.
  assign w_hazard = r_s1_vld && (bus.i_req_setIdx == r_s1_set);
  assign w_rdy    = !w_flush_active && !w_hazard;
  assign w_accept = bus.i_req_vld && w_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_set <= bus.i_req_setIdx;
        r_s1_tag <= bus.i_req_tag;
      end
    end
  end

  // ---------------- s1 compare ----------------
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign w_match[gi]   = r_valid[r_s1_set][gi] && (r_tag[r_s1_set][gi] == r_s1_tag);
    assign w_invalid[gi] = !r_valid[r_s1_set][gi];
  end

  // x & -x isolates the lowest set bit: lowest matching / lowest free way.
  assign w_match_low   = w_match   & (~w_match   + WAYS'(1));
  assign w_invalid_low = w_invalid & (~w_invalid + WAYS'(1));
  assign w_hit         = |w_match;

  always_comb begin
    w_way = bus.i_replace_vec;
    if (w_hit)           w_way = w_match_low;
    else if (|w_invalid) w_way = w_invalid_low;
  end

  assign w_miss_wr = r_s1_vld && !w_hit;

  // ---------------- storage ----------------
  // The flush clear is written after the miss write so that, if both hit the
  // same set at one edge, the clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
    end else begin
      if (w_miss_wr)         r_valid[r_s1_set] <= r_valid[r_s1_set] | w_way;
      if (r_state == FLUSH)  r_valid[r_flush_cnt] <= '0;
    end
  end

  // Tag contents are don't-care after reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (w_miss_wr) begin
      for (int w = 0; w < WAYS; w++) begin
        if (w_way[w]) r_tag[r_s1_set][w] <= r_s1_tag;
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.o_req_rdy    = w_rdy;
  assign bus.o_setIdx     = bus.i_req_setIdx;
  assign bus.o_resp_vld   = r_s1_vld;
  assign bus.o_update_req = r_s1_vld;
  assign bus.o_resp_hit   = r_s1_vld && w_hit;
  assign bus.o_resp_way   = r_s1_vld ? w_way : '0;
  assign bus.o_wayhit_vec = r_s1_vld ? w_way : '0;
endmodule

// File: tb/tb_tag_lookup_pipe.sv
// tb_tag_lookup_pipe
//   Directed and random lookups checked against an array-based reference of
//   the tag store (first matching way, else first free way, else victim).
module tb_tag_lookup_pipe;
  localparam int SETS  = 32;
  localparam int WAYS  = 4;
  localparam int TAG_W = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tag_lookup_pipe_if #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) bus ();

  tag_lookup_pipe #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  int unsigned m_tag   [SETS][WAYS];
  bit          m_valid [SETS][WAYS];

  logic            e_hit;
  logic [WAYS-1:0] e_way;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
  endtask

  task automatic model_lookup(input int s, input int t, input int rv_idx,
                              output logic hit, output logic [WAYS-1:0] way);
    int idx;
    idx = -1;
    hit = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (idx < 0 && m_valid[s][w] && m_tag[s][w] == t) idx = w;
    if (idx >= 0) begin
      hit = 1'b1;
    end else begin
      for (int w = 0; w < WAYS; w++)
        if (idx < 0 && !m_valid[s][w]) idx = w;
      if (idx < 0) idx = rv_idx;
      m_tag[s][idx]   = t;
      m_valid[s][idx] = 1'b1;
    end
    way = WAYS'(1 << idx);
  endtask

  task automatic drive(input int s, input int t, input int rv_idx);
    bus.i_req_vld     = 1'b1;
    bus.i_req_setIdx  = 5'(s);
    bus.i_req_tag     = 20'(t);
    bus.i_replace_vec = WAYS'(1 << rv_idx);
  endtask

  task automatic check_resp(input string name, input int s, input int t, input int rv_idx);
    model_lookup(s, t, rv_idx, e_hit, e_way);
    check({name, "_vld"},    32'(bus.o_resp_vld),   32'd1);
    check({name, "_upd"},    32'(bus.o_update_req), 32'd1);
    check({name, "_hit"},    32'(bus.o_resp_hit),   32'(e_hit));
    check({name, "_way"},    32'(bus.o_resp_way),   32'(e_way));
    check({name, "_wayhit"}, 32'(bus.o_wayhit_vec), 32'(e_way));
  endtask

  task automatic check_idle(input string name);
    check({name, "_vld"},    32'(bus.o_resp_vld),   32'd0);
    check({name, "_upd"},    32'(bus.o_update_req), 32'd0);
    check({name, "_hit"},    32'(bus.o_resp_hit),   32'd0);
    check({name, "_way"},    32'(bus.o_resp_way),   32'd0);
    check({name, "_wayhit"}, 32'(bus.o_wayhit_vec), 32'd0);
  endtask

  // Single isolated lookup: request in s0, response checked in s1.
  task automatic do_lookup(input string name, input int s, input int t, input int rv_idx);
    @(negedge clk);
    drive(s, t, rv_idx);
    #1;
    check({name, "_rdy"}, 32'(bus.o_req_rdy), 32'd1);
    check({name, "_set"}, 32'(bus.o_setIdx),  32'(s));
    @(negedge clk);
    bus.i_req_vld = 1'b0;
    #1;
    check_resp(name, s, t, rv_idx);
  endtask

  // i_flush must already be high; counts cycles with o_req_rdy low.
  task automatic count_flush(input string name, input int hold);
    int cnt;
    bit done;
    cnt  = 0;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (c + 1 >= hold) bus.i_flush = 1'b0;
      #1;
      if (bus.o_req_rdy) done = 1'b1;
      else cnt++;
    end
    check(name, 32'(cnt), 32'd32);
    model_clear();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_req_vld     = 1'b0;
    bus.i_req_setIdx  = '0;
    bus.i_req_tag     = '0;
    bus.i_flush       = 1'b0;
    bus.i_replace_vec = '0;
    model_clear();

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_rdy", 32'(bus.o_req_rdy), 32'd1);
    check_idle("reset");

    // First miss fills first invalid way, then hits two cycles later
    do_lookup("set3_miss", 3, 'hABC, 2);
    do_lookup("set3_hit",  3, 'hABC, 2);
    @(negedge clk); #1;
    check_idle("idle_after_hit");

    // Fill set 5, evict way 2 via replacement vector, old tag now misses
    for (int i = 0; i < 4; i++) do_lookup("set5_fill", 5, 'h500 + i, 0);
    do_lookup("set5_evict",  5, 'h5FF, 2);
    do_lookup("set5_oldtag", 5, 'h502, 1);
    do_lookup("set5_newtag", 5, 'h5FF, 3);

    // Back-to-back same set: one bubble, second sees first's write
    @(negedge clk);
    drive(7, 'h777, 0);
    #1;
    check("b2b_rdy0", 32'(bus.o_req_rdy), 32'd1);
    @(negedge clk);
    #1;
    check("b2b_stall", 32'(bus.o_req_rdy), 32'd0);
    check_resp("b2b_first", 7, 'h777, 0);
    @(negedge clk);
    #1;
    check("b2b_rdy2", 32'(bus.o_req_rdy), 32'd1);
    check("b2b_bubble", 32'(bus.o_resp_vld), 32'd0);
    @(negedge clk);
    bus.i_req_vld = 1'b0;
    #1;
    check_resp("b2b_second", 7, 'h777, 0);

    // Back-to-back differing sets: full throughput
    @(negedge clk);
    drive(8, 'h888, 1);
    #1;
    check("tp_rdy0", 32'(bus.o_req_rdy), 32'd1);
    @(negedge clk);
    drive(9, 'h999, 1);
    #1;
    check("tp_rdy1", 32'(bus.o_req_rdy), 32'd1);
    check_resp("tp_first", 8, 'h888, 1);
    @(negedge clk);
    bus.i_req_vld = 1'b0;
    #1;
    check_resp("tp_second", 9, 'h999, 1);

    // Multi-hot victim leaves duplicate tags; lowest match reported
    for (int i = 0; i < 4; i++) do_lookup("set10_fill", 10, 'hA00 + i, 0);
    @(negedge clk);
    drive(10, 'hBAD, 0);
    bus.i_replace_vec = 4'b1100;
    @(negedge clk);
    bus.i_req_vld = 1'b0;
    #1;
    check("dup_hit", 32'(bus.o_resp_hit), 32'd0);
    check("dup_way", 32'(bus.o_resp_way), 32'h0000000C);
    m_tag[10][2] = 'hBAD; m_valid[10][2] = 1'b1;
    m_tag[10][3] = 'hBAD; m_valid[10][3] = 1'b1;
    do_lookup("dup_lowest", 10, 'hBAD, 0);

    // Random traffic over a few sets with a small tag pool
    for (int n = 0; n < 300; n++) begin
      int s;
      s = (($urandom_range(0, 1) == 0) ? 0 : 16) + int'($urandom_range(0, 3));
      do_lookup("rand", s, int'($urandom_range(0, 6)), int'($urandom_range(0, WAYS - 1)));
    end

    // Flush with a request in s1; repeated flush pulses ignored
    do_lookup("pre_flush_hit", 3, 'hABC, 0);
    @(negedge clk);
    drive(2, 'h222, 0);
    @(negedge clk);
    bus.i_req_vld = 1'b0;
    bus.i_flush   = 1'b1;
    #1;
    check_resp("flush_inflight", 2, 'h222, 0);
    count_flush("flush_rdy_low", 3);
    do_lookup("post_flush_set3", 3, 'hABC, 0);
    do_lookup("post_flush_set2", 2, 'h222, 0);

    // Reset in the middle of a flush
    do_lookup("pop12", 12, 'h121, 0);
    do_lookup("pop20", 20, 'h202, 0);
    do_lookup("pop31", 31, 'h313, 0);
    do_lookup("pop20_hit", 20, 'h202, 0);
    @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("midflush_rdy", 32'(bus.o_req_rdy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_clear();
    check("rst_abort_rdy", 32'(bus.o_req_rdy), 32'd1);
    check_idle("rst_abort");
    do_lookup("rst_set12", 12, 'h121, 0);
    do_lookup("rst_set20", 20, 'h202, 0);
    do_lookup("rst_set31", 31, 'h313, 0);

    // Flush counter restarts cleanly after the aborted sweep
    @(negedge clk);
    bus.i_flush = 1'b1;
    count_flush("flush_after_rst", 1);
    do_lookup("post_flush2", 20, 'h202, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tag_lookup_pipe.md
TAG_LOOKUP_PIPE -- requirements
Module: tag_lookup_pipe

Interface
REQ-001 SHALL have parameter SETS, default 32, number of sets (power of 2).
REQ-002 SHALL have parameter WAYS, default 4, associativity (power of 2, >=2).
REQ-003 SHALL have parameter TAG_W, default 20, tag width in bits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 i_req_vld  input  1  lookup request valid.
REQ-007 o_req_rdy  output  1  block can accept a request this cycle.
REQ-008 i_req_setIdx  input  $clog2(SETS)  request set index.
REQ-009 i_req_tag  input  TAG_W  request tag.
REQ-010 i_flush  input  1  single-cycle pulse; invalidate all lines.
REQ-011 o_setIdx  output  $clog2(SETS)  set index driven to the replacement block in s0.
REQ-012 i_replace_vec  input  WAYS  one-hot victim from the replacement block, valid in s1 for the s0 set.
REQ-013 o_update_req  output  1  replacement update strobe, s1.
REQ-014 o_wayhit_vec  output  WAYS  one-hot accessed way (hit way or allocated victim), s1.
REQ-015 o_resp_vld, o_resp_hit  output  1 each  lookup result valid / hit flag, s1.
REQ-016 o_resp_way  output  WAYS  one-hot way of the result, s1.

Function
REQ-017 SHALL hold tag[SETS][WAYS] and valid[SETS][WAYS] in registers.
REQ-018 s0: request accepted when i_req_vld && o_req_rdy; o_setIdx = i_req_setIdx combinationally; setIdx and tag registered into s1.
REQ-019 s1, one cycle after acceptance: compare the registered tag against all valid ways of the set; hit = any match.
REQ-020 Hit: o_resp_hit=1, o_resp_way = o_wayhit_vec = matching way, o_update_req=1.
REQ-021 Miss: prefer the lowest-index invalid way; else i_replace_vec; at the s1 edge write tag, set valid; o_resp_hit=0; o_resp_way = o_wayhit_vec = chosen way; o_update_req=1.
REQ-022 o_resp_vld and o_update_req SHALL be 1 exactly in s1 of accepted requests; all s1 outputs SHALL be 0 otherwise.
REQ-023 Latency: accept cycle N -> response cycle N+1; throughput 1/cycle for differing sets.
REQ-024 Same-set hazard: o_req_rdy=0 when s1 is valid and i_req_setIdx equals the s1 setIdx (one bubble), so the replacement state is updated before reuse.
REQ-025 A tag array write at an s1 edge SHALL be visible to the next s1 compare.
REQ-026 FSM states RUN and FLUSH; RUN->FLUSH on i_flush; FLUSH clears valid of one set per cycle via a $clog2(SETS) counter from 0; FLUSH->RUN after set SETS-1 is cleared (SETS cycles).
REQ-027 In FLUSH, o_req_rdy=0; a request already in s1 when i_flush arrives SHALL complete normally, and its miss write SHALL then be cleared by the flush.
REQ-028 i_flush while in FLUSH SHALL be ignored (counter not restarted).
REQ-029 Multiple matching ways (illegal) SHALL report the lowest-index match.

Reset
REQ-030 On rst: all valid bits 0, s1 invalid, FSM=RUN, flush counter 0, o_req_rdy=1, all other outputs 0; tag contents undefined.
REQ-031 rst mid-FLUSH SHALL abort the flush and return to RUN with all valid bits cleared.

Verification
REQ-032 After reset, request set 3, tag 0xABC -> next cycle resp_vld=1, hit=0, way=0001 (first invalid), update_req=1.
REQ-033 Repeat set 3, tag 0xABC two cycles later -> hit=1, way=0001, wayhit_vec=0001.
REQ-034 Fill set 5 with 4 tags, then a 5th tag while i_replace_vec=0100 -> miss, way=0100; the old way-2 tag now misses.
REQ-035 Back-to-back requests to set 7 -> o_req_rdy=0 for one cycle, second response two cycles after the first.
REQ-036 Pulse i_flush -> o_req_rdy=0 for exactly 32 cycles; afterwards a previously hitting tag misses.
REQ-037 Assert rst at flush cycle 10 -> next cycle o_req_rdy=1 and every set misses.
